// File: rtl/depth_test_writer.sv
// depth_test_writer: clips rasterizer fragments, depth-tests them against an
// internal depth buffer, and writes the passing ones to the framebuffer.
// A clear engine sweeps every pixel to the far depth and CLEAR_COLOR.
module depth_test_writer #(
  parameter int                   COORD_WIDTH     = 32,
  parameter int                   DEPTH_BIT_WIDTH = 16,
  parameter int                   COLOR_WIDTH     = 16,
  parameter int                   FB_WIDTH        = 320,
  parameter int                   FB_HEIGHT       = 180,
  parameter logic [COLOR_WIDTH-1:0] CLEAR_COLOR   = '0,
  localparam int                  NPIX            = FB_WIDTH * FB_HEIGHT,
  localparam int                  ADDR_WIDTH      = $clog2(NPIX)
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       pixel_valid,
  output logic                       pixel_ready,
  input  logic [COORD_WIDTH-1:0]     pixel_x,
  input  logic [COORD_WIDTH-1:0]     pixel_y,
  input  logic [DEPTH_BIT_WIDTH-1:0] pixel_depth,
  input  logic [COLOR_WIDTH-1:0]     pixel_color,
  input  logic                       clear_start,
  output logic                       clear_busy,
  output logic                       clear_done,
  output logic                       fb_we,
  output logic [ADDR_WIDTH-1:0]      fb_addr,
  output logic [COLOR_WIDTH-1:0]     fb_data,
  output logic [31:0]                pass_count,
  output logic [31:0]                reject_count,
  output logic [31:0]                clip_count
);
  typedef logic [ADDR_WIDTH-1:0]      addr_t;
  typedef logic [DEPTH_BIT_WIDTH-1:0] depth_t;

  typedef struct packed {
    logic                   v;
    addr_t                  addr;
    depth_t                 depth;
    logic [COLOR_WIDTH-1:0] color;
  } frag_t;

  // Recent depth-buffer write, kept to cover writes the BRAM read missed
  typedef struct packed {
    logic   v;
    addr_t  addr;
    depth_t depth;
  } dwr_t;

  typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;

  state_t state;
  addr_t  clr_addr;
  frag_t  s1, s2, s3;
  dwr_t   w1, w2;
  depth_t mem [NPIX];
  depth_t q1, q2;

  logic   accept, in_bounds, clearing, clr_last, s3_pass;
  addr_t  s0_addr;
  depth_t stored;
  logic   dw_we;
  addr_t  dw_addr;
  depth_t dw_data;

  assign pixel_ready = (state == IDLE);
  assign clear_busy  = (state != IDLE);
  assign accept      = pixel_valid && pixel_ready;
  assign clearing    = (state == CLEAR);
  assign clr_last    = clearing && (clr_addr == addr_t'(NPIX - 1));

  // Sign bit clear means non-negative, so the upper compare can be unsigned
  assign in_bounds = !pixel_x[COORD_WIDTH-1] && (pixel_x < COORD_WIDTH'(FB_WIDTH)) &&
                     !pixel_y[COORD_WIDTH-1] && (pixel_y < COORD_WIDTH'(FB_HEIGHT));
  assign s0_addr   = addr_t'(pixel_y[ADDR_WIDTH-1:0] * addr_t'(FB_WIDTH) + pixel_x[ADDR_WIDTH-1:0]);

  // Newest in-flight write wins over older ones and over the BRAM data
  always_comb begin
    stored = q2;
    if (w2.v && w2.addr == s3.addr) stored = w2.depth;
    if (w1.v && w1.addr == s3.addr) stored = w1.depth;
  end

  assign s3_pass = s3.v && (s3.depth < stored);

  // Clear and fragment writes never overlap: DRAIN empties the pipe first
  assign dw_we   = clearing || s3_pass;
  assign dw_addr = clearing ? clr_addr : s3.addr;
  assign dw_data = clearing ? '1 : s3.depth;

  assign fb_we   = dw_we;
  assign fb_addr = dw_we ? dw_addr : '0;
  assign fb_data = clearing ? CLEAR_COLOR : (s3_pass ? s3.color : '0);

  // Depth buffer: write port plus a two-register read path (BRAM style)
  always_ff @(posedge clk_in) begin
    if (dw_we) mem[dw_addr] <= dw_data;
    q1 <= mem[s1.addr];
    q2 <= q1;
  end

  // Fragment pipeline stages and write history for forwarding
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
      w1 <= '0;
      w2 <= '0;
    end else begin
      s1 <= '{v: accept && in_bounds, addr: s0_addr, depth: pixel_depth, color: pixel_color};
      s2 <= s1;
      s3 <= s2;
      w1 <= '{v: dw_we, addr: dw_addr, depth: dw_data};
      w2 <= w1;
    end
  end

  // Control FSM: drain in-flight fragments, then sweep all addresses
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state      <= IDLE;
      clr_addr   <= '0;
      clear_done <= 1'b0;
    end else begin
      clear_done <= 1'b0;
      case (state)
        IDLE:  if (clear_start) state <= DRAIN;
        // s3 retires this cycle, so only s1/s2 need to be empty
        DRAIN: if (!s1.v && !s2.v) begin
          state    <= CLEAR;
          clr_addr <= '0;
        end
        CLEAR: if (clr_last) begin
          state      <= IDLE;
          clear_done <= 1'b1;
        end else begin
          clr_addr <= clr_addr + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Saturating statistics, zeroed when a clear completes
  always_ff @(posedge clk_in) begin
    if (rst_in || clr_last) begin
      pass_count   <= '0;
      reject_count <= '0;
      clip_count   <= '0;
    end else begin
      if (s3_pass && pass_count != '1)               pass_count   <= pass_count + 1;
      if (s3.v && !s3_pass && reject_count != '1)    reject_count <= reject_count + 1;
      if (accept && !in_bounds && clip_count != '1)  clip_count   <= clip_count + 1;
    end
  end
endmodule

// File: doc/depth_test_writer.md
Name: depth_test_writer

Overview:
Receiving end of the rasterizer pixel stream: accepts (x, y, depth, color) fragments, clips them to the framebuffer, and runs a per-pixel depth test against an internal depth buffer. Fragments that pass update the depth buffer and emit a framebuffer write. A clear engine resets every depth entry to the far value and writes CLEAR_COLOR to the framebuffer. The block sits between the rasterizer and the frame-buffer BRAM.

Parameters:
COORD_WIDTH, 32, width of the signed pixel coordinates
DEPTH_BIT_WIDTH, 16, depth width; smaller value means closer
COLOR_WIDTH, 16, framebuffer pixel width
FB_WIDTH, 320, framebuffer width in pixels
FB_HEIGHT, 180, framebuffer height in pixels
CLEAR_COLOR, 0, color written to every pixel during a clear
(ADDR_WIDTH = $clog2(FB_WIDTH*FB_HEIGHT), derived localparam)

Ports:
clk_in  in  1  system clock
rst_in  in  1  synchronous active-high reset
pixel_valid  in  1  fragment present
pixel_ready  out  1  block can accept a fragment
pixel_x  in  COORD_WIDTH  signed x
pixel_y  in  COORD_WIDTH  signed y
pixel_depth  in  DEPTH_BIT_WIDTH  fragment depth
pixel_color  in  COLOR_WIDTH  fragment color
clear_start  in  1  one-cycle request to clear the buffers
clear_busy  out  1  clear in progress, including the drain phase
clear_done  out  1  one-cycle pulse when the clear completes
fb_we  out  1  framebuffer write strobe
fb_addr  out  ADDR_WIDTH  framebuffer address, y*FB_WIDTH+x
fb_data  out  COLOR_WIDTH  framebuffer write data
pass_count  out  32  fragments written since the last clear
reject_count  out  32  fragments that failed the depth test since the last clear
clip_count  out  32  fragments dropped as out of bounds since the last clear

Behaviour:
- One clock; reset is synchronous and active-high.
- On reset: all outputs 0 except pixel_ready=1; state IDLE; pipeline emptied; counters 0. Depth buffer contents are undefined after reset, so software issues a clear before the first frame.
- A fragment is accepted when pixel_valid && pixel_ready.
- States:
  - IDLE: pixel_ready=1.
  - DRAIN: pixel_ready=0; hold until the pipeline is empty (at most 3 cycles).
  - CLEAR: pixel_ready=0.
- Transitions:
  - IDLE -> DRAIN on clear_start. A fragment accepted in the same cycle as clear_start is processed normally before the clear begins.
  - DRAIN -> CLEAR when the pipeline is empty.
  - CLEAR visits address 0..FB_WIDTH*FB_HEIGHT-1 at one address per cycle. Each cycle: depth entry = all-ones, fb_we=1, fb_data=CLEAR_COLOR.
  - After the last address: one-cycle clear_done pulse, counters zeroed, return to IDLE.
- clear_busy=1 in DRAIN and CLEAR. clear_start is ignored while clear_busy=1.
- Fragment pipeline (fully pipelined, one fragment per cycle, no backpressure from the framebuffer):
  - S0 (accept cycle N): bounds check. The fragment is out of bounds if x<0, x>=FB_WIDTH, y<0 or y>=FB_HEIGHT (signed compares). Out-of-bounds fragments increment clip_count and are marked invalid.
  - Address computed and registered; depth read issued. The depth buffer is inferred BRAM with 2-cycle read latency.
  - S3 (cycle N+3): compare. Pass iff pixel_depth < stored depth (strict). A fragment with equal depth is rejected.
  - On pass: the depth entry is written, fb_we=1, fb_addr, fb_data=pixel_color, pass_count++. On fail: reject_count++, fb_we=0.
  - Latency from accept to fb_we is exactly 3 cycles.
- Hazard forwarding: if an earlier in-flight fragment wrote the same address after this fragment's read was issued, the compare uses the newest in-flight written depth instead of the BRAM data. A back-to-back fragment stream therefore gives the same result as serial processing.
- The counters saturate at 2^32-1.
- fb_we is 0 on every cycle with no write.
- Reset mid-clear: return to IDLE immediately; no clear_done pulse; partially cleared contents are undefined.

Test Plan:
- FB 8x4. Clear, then check: 32 consecutive fb_we with addr 0..31 and data CLEAR_COLOR; clear_done pulses once, on the cycle after address 31; pixel_ready=0 throughout.
- After a clear, send fragment (3,2,depth=100,color=5) -> fb_we 3 cycles later, addr 19, data 5, pass_count=1.
- Same pixel again at depth 100 -> rejected. Then depth 99, color 7 -> written, addr 19. Expect reject_count=1, pass_count=2.
- Back-to-back fragments to (1,1) with depths 50, 60, 40 -> writes for 50 and 40 only (forwarding check). The 60 fragment is rejected.
- Fragments (-1,0), (8,0), (0,4), (0,-5) -> no fb_we; clip_count=4.
- clear_start in the same cycle as an accepted fragment -> that fragment's write appears before the first clear write. Asserting rst_in mid-clear -> outputs return to reset values with no clear_done pulse.
